usb_lock_mon_regs: RTL
======================

USB_LOCK_MON_REGS -- requirements
Module: usb_lock_mon_regs

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of monitored lock channels (legal 1..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of each lock-loss counter (legal 8..16).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on locked inputs (legal 2..3).
REQ-004 SHALL have port: clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: penable  input  1  APB enable phase.
REQ-007 SHALL have port: psel  input  1  APB select.
REQ-008 SHALL have port: paddr  input  40  byte address; only paddr[11:2] decoded.
REQ-009 SHALL have port: pwrite  input  1  1 = write, 0 = read.
REQ-010 SHALL have port: pwdata  input  32  write data.
REQ-011 SHALL have port: prdata  output  32  read data, combinational from paddr and register state.
REQ-012 SHALL have port: locked  input  NUM_CH  per-channel lock status, asynchronous to clk.
REQ-013 SHALL have port: irq  output  1  registered level interrupt.

Function
REQ-014 SHALL pass each locked[i] through SYNC_STAGES flops; lsync[i] is the last stage.
REQ-015 SHALL register lsync into lprev; loss event[i] = lprev[i] & ~lsync[i]; rising edges generate no event.
REQ-016 SHALL perform a write only when psel && penable && pwrite, on that edge.
REQ-017 SHALL decode {paddr[11:2],2'b00}; 0x000 ID (RO) = {16'h5542, 8'h02, 8'(NUM_CH)}.
REQ-018 SHALL map 0x004 IRQ_SUMMARY (RO) = bit i set when sticky[i] && irq_en[i]; upper bits 0.
REQ-019 SHALL map per-channel block at 0x100 + 0x10*i: +0x0 STATUS, +0x4 LOSS_CNT, +0x8 IRQ_EN.
REQ-020 SHALL read STATUS as {30'h0, sticky[i], lsync[i]}; writing 1 to bit 1 clears sticky[i] (W1C), bit 0 ignored.
REQ-021 SHALL read LOSS_CNT zero-extended; any write clears it to 0.
REQ-022 SHALL read/write IRQ_EN bit 0 as irq_en[i]; other bits read 0.
REQ-023 SHALL set sticky[i] on the edge where event[i] is high.
REQ-024 SHALL increment cnt[i] on each event edge, saturating at all-ones (no wrap).
REQ-025 SHALL give set priority when event and sticky W1C coincide: sticky stays 1.
REQ-026 SHALL load cnt[i] = 1 when event coincides with LOSS_CNT write.
REQ-027 SHALL register irq = |(sticky & irq_en), one edge after sticky/irq_en change.
REQ-028 SHALL make sticky visible SYNC_STAGES+1 edges after the first edge sampling locked low; irq one edge later.
REQ-029 SHALL return prdata 0 and ignore writes for unmapped offsets and channel indices >= NUM_CH.
REQ-030 SHALL produce no side effects on reads.

Reset
REQ-031 SHALL clear on reset: synchroniser stages, lprev, sticky, cnt, irq_en, irq (all 0).
REQ-032 SHALL generate no loss event on the first cycles after reset, regardless of locked level.
REQ-033 SHALL abandon any in-flight event when reset asserts mid-operation; no sticky/count survives reset.

Structure
REQ-034 SHALL place address offsets, ID constant, per-channel stride, and STATUS bit positions in package usb_regs_pkg.
REQ-035 SHALL implement per-channel sync, edge detect, sticky, and counter in sub-module usb_lock_mon, instantiated NUM_CH times via generate.

Verification
REQ-036 SHALL cover: after reset, read 0x000 with NUM_CH=4 -> 0x55420204; all STATUS/LOSS_CNT reads 0; irq 0.
REQ-037 SHALL cover: locked[1] 1->0 -> 0x110 reads 0x2 at edge SYNC_STAGES+1; 0x114 reads 1; irq stays 0 (irq_en clear).
REQ-038 SHALL cover: write 0x118=1 with sticky[1] set -> irq 1 next edge; write 0x110=0x2 -> sticky clears, irq 0 one edge later.
REQ-039 SHALL cover: CNT_W=8, 300 loss events on ch0 -> 0x104 reads 0xFF.
REQ-040 SHALL cover: W1C and LOSS_CNT write coincident with event edge -> sticky 1, cnt 1.
REQ-041 SHALL cover: read 0x100+0x10*NUM_CH and 0x00C -> 0; write there -> no state change.

Source files
------------

// File: rtl/usb_regs_pkg.sv
// Shared constants for the USB lock-loss monitor register block:
// register map offsets, ID word layout, per-channel stride and STATUS bits.
package usb_regs_pkg;

  localparam logic [11:0] ADDR_ID          = 12'h000;
  localparam logic [11:0] ADDR_IRQ_SUMMARY = 12'h004;

  // Per-channel register blocks start at CH_BASE and repeat every CH_STRIDE
  // bytes, so the channel index sits in offset bits [7:4].
  localparam logic [11:0] CH_BASE   = 12'h100;
  localparam logic [11:0] CH_STRIDE = 12'h010;

  localparam logic [3:0] OFF_STATUS   = 4'h0;
  localparam logic [3:0] OFF_LOSS_CNT = 4'h4;
  localparam logic [3:0] OFF_IRQ_EN   = 4'h8;

  localparam logic [15:0] ID_MAGIC   = 16'h5542;
  localparam logic [7:0]  ID_VERSION = 8'h02;

  localparam int STATUS_LSYNC_BIT  = 0;
  localparam int STATUS_STICKY_BIT = 1;

  typedef enum logic [1:0] {
    REG_NONE     = 2'd0,
    REG_STATUS   = 2'd1,
    REG_LOSS_CNT = 2'd2,
    REG_IRQ_EN   = 2'd3
  } ch_reg_e;

  // ID register contents for a given channel count.
  function automatic logic [31:0] id_word(input logic [7:0] num_ch);
    return {ID_MAGIC, ID_VERSION, num_ch};
  endfunction

  // Map the low nibble of a channel-block offset onto a register kind.
  function automatic ch_reg_e decode_ch_reg(input logic [3:0] sub);
    ch_reg_e kind;
    case (sub)
      OFF_STATUS:   kind = REG_STATUS;
      OFF_LOSS_CNT: kind = REG_LOSS_CNT;
      OFF_IRQ_EN:   kind = REG_IRQ_EN;
      default:      kind = REG_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/usb_lock_mon_regs_if.sv
// APB-style register bus bundle for the lock monitor.
interface usb_lock_mon_regs_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [39:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/usb_lock_mon.sv
// One lock channel: synchroniser, falling-edge (loss) detect, sticky flag
// and saturating loss counter.
module usb_lock_mon #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_locked,
  input  logic             i_clr_sticky,
  input  logic             i_clr_cnt,
  output logic             o_lsync,
  output logic             o_sticky,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_lprev;
  logic                   r_sticky;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_lsync;
  logic                   w_event;
  logic                   w_cnt_sat;

  assign w_lsync   = r_sync[SYNC_STAGES-1];
  // Reset clears lprev, so no event can fire until a high level has been seen.
  assign w_event   = r_lprev & ~w_lsync;
  assign w_cnt_sat = &r_cnt;

  // Shift the asynchronous lock level through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_locked};
    end
  end

  // Remember the previous synchronised level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lprev <= 1'b0;
    end else begin
      r_lprev <= w_lsync;
    end
  end

  // Sticky loss flag; a new loss wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky <= 1'b0;
    end else if (w_event) begin
      r_sticky <= 1'b1;
    end else if (i_clr_sticky) begin
      r_sticky <= 1'b0;
    end else begin
      r_sticky <= r_sticky;
    end
  end

  // Saturating loss counter; a loss coinciding with a clear counts as one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_event) begin
      if (i_clr_cnt) begin
        r_cnt <= CNT_ONE;
      end else if (w_cnt_sat) begin
        r_cnt <= r_cnt;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end else if (i_clr_cnt) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_lsync  = w_lsync;
  assign o_sticky = r_sticky;
  assign o_cnt    = r_cnt;

endmodule

// File: rtl/usb_lock_mon_regs.sv
// Lock-loss monitor register block: NUM_CH channel monitors behind an
// APB-style register map with a registered level interrupt.
module usb_lock_mon_regs
  import usb_regs_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  usb_lock_mon_regs_if.slave  apb,
  input  logic [NUM_CH-1:0]   locked,
  output logic                irq
);

  logic [11:0]       w_off;
  logic              w_wr;
  logic              w_in_ch;
  logic [3:0]        w_ch_idx;
  ch_reg_e           w_reg;
  logic [NUM_CH-1:0] w_ch_sel;
  logic [NUM_CH-1:0] w_clr_sticky;
  logic [NUM_CH-1:0] w_clr_cnt;
  logic [NUM_CH-1:0] w_en_wr;
  logic [NUM_CH-1:0] w_lsync;
  logic [NUM_CH-1:0] w_sticky;
  logic [CNT_W-1:0]  w_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_irq_en;
  logic              r_irq;
  logic [31:0]       w_irq_sum;
  logic              w_sel_lsync;
  logic              w_sel_sticky;
  logic              w_sel_en;
  logic [CNT_W-1:0]  w_sel_cnt;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_off    = {apb.paddr[11:2], 2'b00};
  assign w_wr     = apb.psel & apb.penable & apb.pwrite;
  assign w_in_ch  = (w_off[11:8] == CH_BASE[11:8]);
  assign w_ch_idx = w_off[7:4];
  assign w_reg    = w_in_ch ? decode_ch_reg(w_off[3:0]) : REG_NONE;
  assign w_unused = ^{apb.paddr[39:12], apb.paddr[1:0], apb.pwdata[31:2]};

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      // Channels at or beyond NUM_CH never match, so they read 0 and ignore writes.
      assign w_ch_sel[g]     = w_in_ch && (w_ch_idx == 4'(g));
      assign w_clr_sticky[g] = w_wr && w_ch_sel[g] && (w_reg == REG_STATUS)
                               && apb.pwdata[STATUS_STICKY_BIT];
      assign w_clr_cnt[g]    = w_wr && w_ch_sel[g] && (w_reg == REG_LOSS_CNT);
      assign w_en_wr[g]      = w_wr && w_ch_sel[g] && (w_reg == REG_IRQ_EN);

      usb_lock_mon #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_mon (
        .clk          (clk),
        .reset        (reset),
        .i_locked     (locked[g]),
        .i_clr_sticky (w_clr_sticky[g]),
        .i_clr_cnt    (w_clr_cnt[g]),
        .o_lsync      (w_lsync[g]),
        .o_sticky     (w_sticky[g]),
        .o_cnt        (w_cnt[g])
      );
    end
  endgenerate

  // Per-channel interrupt enables, written through IRQ_EN bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_en <= {NUM_CH{1'b0}};
    end else begin
      r_irq_en <= (r_irq_en & ~w_en_wr) | (w_en_wr & {NUM_CH{apb.pwdata[0]}});
    end
  end

  // Level interrupt, registered from the enabled sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(w_sticky & r_irq_en);
    end
  end

  // Read mux: pick the addressed channel by OR-ing one-hot selects, then format.
  always_comb begin
    w_irq_sum    = 32'h0;
    w_sel_lsync  = 1'b0;
    w_sel_sticky = 1'b0;
    w_sel_en     = 1'b0;
    w_sel_cnt    = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      w_irq_sum[i] = w_sticky[i] & r_irq_en[i];
      w_sel_lsync  = w_sel_lsync  | (w_ch_sel[i] & w_lsync[i]);
      w_sel_sticky = w_sel_sticky | (w_ch_sel[i] & w_sticky[i]);
      w_sel_en     = w_sel_en     | (w_ch_sel[i] & r_irq_en[i]);
      w_sel_cnt    = w_sel_cnt    | ({CNT_W{w_ch_sel[i]}} & w_cnt[i]);
    end
    w_rdata = 32'h0;
    if (w_off == ADDR_ID) begin
      w_rdata = id_word(8'(NUM_CH));
    end else if (w_off == ADDR_IRQ_SUMMARY) begin
      w_rdata = w_irq_sum;
    end else if (|w_ch_sel) begin
      case (w_reg)
        REG_STATUS:   w_rdata = {30'h0, w_sel_sticky, w_sel_lsync};
        REG_LOSS_CNT: w_rdata = {{(32-CNT_W){1'b0}}, w_sel_cnt};
        REG_IRQ_EN:   w_rdata = {31'h0, w_sel_en};
        default:      w_rdata = 32'h0;
      endcase
    end else begin
      w_rdata = 32'h0;
    end
  end

  assign apb.prdata = w_rdata;
  assign irq        = r_irq;

endmodule
